rotation_amount_finder: RTL and testbench

- Multi-cycle inverse of the calculator's sequential rotator: given an original operand and a rotated result, finds the rotation count that maps one onto the other.
- Steps a one-position rotator over the original once per clock and compares it against the target each cycle.
- Reports the minimal count, or "not found", through a start/busy/done handshake.
- Sits beside the rotator in the calculator datapath; used for rotate-amount recovery and self-check.

---
 rtl/rotation_amount_finder.sv | 112 +++++++++++
 tb/tb_rotation_amount_finder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/rotation_amount_finder.sv
// Multi-cycle rotation-count search: rotates a latched operand one position per
// clock and reports the smallest count that reproduces the latched target.
module rotation_amount_finder #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] orig,
  input  logic [WIDTH-1:0] target,
  input  logic             dir,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [CNT_W-1:0] cnt,
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled only while idle; busy covers SEARCH and DONE;
  // done is a one-cycle pulse and found/cnt remain valid until the next accepted start.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] STEP_MAX = CNT_W'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic [WIDTH-1:0] r_tgt, w_tgt_nxt;
  logic             r_dir, w_dir_nxt;
  logic [CNT_W-1:0] r_step, w_step_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_found, w_found_nxt;
  logic             r_busy, r_done;
  logic [WIDTH-1:0] w_rot;

  assign w_rot = r_dir ? {r_data[0], r_data[WIDTH-1:1]}
                       : {r_data[WIDTH-2:0], r_data[WIDTH-1]};

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_tgt_nxt   = r_tgt;
    w_dir_nxt   = r_dir;
    w_step_nxt  = r_step;
    w_cnt_nxt   = r_cnt;
    w_found_nxt = r_found;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_data_nxt  = orig;
          w_tgt_nxt   = target;
          w_dir_nxt   = dir;
          w_step_nxt  = '0;
          w_state_nxt = SEARCH;
        end
      end
      SEARCH: begin
        // Step 0 is compared first, so the first hit is the minimal count.
        if (r_data == r_tgt) begin
          w_found_nxt = 1'b1;
          w_cnt_nxt   = r_step;
          w_state_nxt = DONE;
        end else if (r_step == STEP_MAX) begin
          w_found_nxt = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = DONE;
        end else begin
          w_data_nxt = w_rot;
          w_step_nxt = r_step + 1'b1;
        end
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_tgt   <= '0;
      r_dir   <= 1'b0;
      r_step  <= '0;
      r_cnt   <= '0;
      r_found <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_tgt   <= w_tgt_nxt;
      r_dir   <= w_dir_nxt;
      r_step  <= w_step_nxt;
      r_cnt   <= w_cnt_nxt;
      r_found <= w_found_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      // The pulse lands in the cycle after DONE, one edge after the result registers.
      r_done  <= (r_state == DONE);
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign found     = r_found;
  assign cnt       = r_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_rotation_amount_finder.sv
// Directed and random checks of rotation_amount_finder: result, latency,
// busy length, done pulse width, ignored restarts and asynchronous abort.
module tb_rotation_amount_finder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] orig, target;
  logic       dir;
  logic       busy, done, found;
  logic [1:0] cnt;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_q[$];
  int         lat_q[$];

  rotation_amount_finder #(.WIDTH(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .orig(orig), .target(target),
    .dir(dir), .busy(busy), .done(done), .found(found), .cnt(cnt),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference search written directly from the rotation definition.
  function automatic logic [2:0] model(input logic [3:0] o, input logic [3:0] t, input logic d);
    logic [3:0] v;
    v = o;
    for (int s = 0; s < 4; s++) begin
      if (v == t) return {1'b1, 2'(s)};
      v = d ? {v[0], v[3:1]} : {v[2:0], v[3]};
    end
    return 3'b000;
  endfunction

  task automatic run_search(input logic [3:0] o, input logic [3:0] t, input logic d,
                            input bit glitch, input string tag);
    logic [2:0] e, got;
    int lat_exp, busy_n, extra;
    bit seen;
    e = model(o, t, d);
    exp_q.push_back(e);
    lat_q.push_back(e[2] ? int'(e[1:0]) + 2 : 5);
    @(negedge clk);
    start = 1'b1; orig = o; target = t; dir = d;
    @(posedge clk);
    busy_n = 0; seen = 0;
    for (int ed = 0; ed < 20 && !seen; ed++) begin
      @(negedge clk);
      if (ed == 0) begin
        start  = glitch;
        orig   = 4'($urandom);
        target = glitch ? orig : 4'($urandom);
        dir    = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen    = 1;
        got     = {found, cnt};
        e       = exp_q.pop_front();
        lat_exp = lat_q.pop_front();
        check({tag, "_found"}, 32'(got[2]), 32'(e[2]));
        check({tag, "_cnt"}, 32'(got[1:0]), 32'(e[1:0]));
        check({tag, "_latency"}, 32'(ed), 32'(lat_exp));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(lat_exp));
      end else if (busy) begin
        busy_n++;
      end
    end
    if (!seen) begin
      void'(exp_q.pop_front());
      void'(lat_q.pop_front());
      check({tag, "_done_timeout"}, 32'd0, 32'd1);
    end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check({tag, "_extra_done"}, 32'(extra), 32'd0);
    check({tag, "_found_hold"}, 32'({found, cnt}), 32'(got));
  endtask

  initial begin
    logic [3:0] ro, rt;
    logic       rd;
    int         dn;
    rst = 1'b0; start = 1'b0; orig = '0; target = '0; dir = 1'b0;
    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_found", 32'(found), 32'd0);
    check("reset_cnt", 32'(cnt), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_search(4'b0011, 4'b0110, 1'b0, 1'b0, "left_1");
    run_search(4'b0011, 4'b0110, 1'b1, 1'b0, "right_3");
    run_search(4'b1010, 4'b0101, 1'b0, 1'b0, "periodic");
    run_search(4'b0000, 4'b0000, 1'b0, 1'b0, "zero");
    run_search(4'b0011, 4'b0111, 1'b0, 1'b0, "no_match");
    run_search(4'b0011, 4'b0110, 1'b0, 1'b1, "restart_ignored");
    for (int i = 0; i < 6; i++) begin
      ro = 4'($urandom_range(0, 15));
      rd = 1'($urandom_range(0, 1));
      rt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                       : (rd ? {ro[1:0], ro[3:2]} : {ro[2:0], ro[3]});
      run_search(ro, rt, rd, 1'b0, "random");
    end

    // Leave found=1 behind so the abort check below sees a real clear.
    run_search(4'b1000, 4'b0100, 1'b1, 1'b0, "pre_abort");
    @(negedge clk);
    start = 1'b1; orig = 4'b0011; target = 4'b0111; dir = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_found", 32'(found), 32'd0);
    check("abort_cnt", 32'(cnt), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_no_done", 32'(dn), 32'd0);
    run_search(4'b0011, 4'b1001, 1'b1, 1'b0, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
